mac_dot_seq: RTL and testbench

Dot-product sequencer that owns one `part3_mac` instance.
- Accepts N (a,b) operand pairs on a valid/ready stream and buffers them.
- Feeds them to the MAC back-to-back, counts the MAC's `valid_out` pulses and captures the final saturated accumulator.
- Presents the result on a valid/ready output, then clears the MAC for the next vector.
- Sits between the operand source and the MAC.

---
 rtl/mac_dot_seq.sv | 102 ++++++++++
 tb/tb_mac_dot_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Buffers N operand pairs, streams them into an external saturating MAC, captures the Nth result and clears the MAC.
// Result appears N+4 cycles after the last accepted pair; m_ready low holds OUT, and no pairs are accepted until LOAD.
module mac_dot_seq #(
   parameter int N  = 4,
   parameter int DW = 10,
   parameter int OW = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic signed [DW-1:0] s_a,
   input  logic signed [DW-1:0] s_b,
   output logic                 mac_reset,
   output logic                 mac_valid_in,
   output logic signed [DW-1:0] mac_a,
   output logic signed [DW-1:0] mac_b,
   input  logic signed [OW-1:0] mac_f,
   input  logic                 mac_valid_out,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic signed [OW-1:0] m_data,
   output logic                 busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [2:0] {CLEAR, LOAD, RUN, DRAIN, OUT} state_t;

   typedef struct packed {
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
   } pair_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  wr_cnt, rd_cnt, res_cnt;
   pair_t          pair_buf [N];
   logic           s_fire;
   logic           res_phase;
   logic           res_last;

   assign s_fire    = s_valid && s_ready;
   assign res_phase = (state == RUN) || (state == DRAIN);
   assign res_last  = res_phase && mac_valid_out && (res_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset) state <= CLEAR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR: state_nxt = LOAD;
         LOAD:  if (s_fire && (wr_cnt == LAST)) state_nxt = RUN;
         RUN:   if (rd_cnt == LAST) state_nxt = DRAIN;
         DRAIN: if (res_last) state_nxt = OUT;
         OUT:   if (m_ready) state_nxt = CLEAR;
         default: state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      s_ready      = (state == LOAD);
      busy         = (state != LOAD);
      mac_reset    = (state == CLEAR);
      mac_valid_in = (state == RUN);
      m_valid      = (state == OUT);
      mac_a        = '0;
      mac_b        = '0;
      if (state == RUN) begin
         mac_a = pair_buf[rd_cnt].a;
         mac_b = pair_buf[rd_cnt].b;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         res_cnt <= '0;
         m_data  <= '0;
      end else begin
         if (s_fire)
            wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + CW'(1);
         if (state == RUN)
            rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + CW'(1);
         // Early pulses land during RUN; the last one always lands in DRAIN.
         if (res_phase && mac_valid_out)
            res_cnt <= res_last ? '0 : res_cnt + CW'(1);
         if (res_last && (state == DRAIN))
            m_data <= mac_f;
      end
   end

   // Buffer contents need no reset; wr_cnt gates every write.
   always_ff @(posedge clk) begin
      if (s_fire) pair_buf[wr_cnt] <= '{a: s_a, b: s_b};
   end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq with a behavioural 3-cycle saturating MAC attached to its MAC port.
module tb_mac_dot_seq;
   localparam int N  = 4;
   localparam int DW = 10;
   localparam int OW = 20;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic signed [DW-1:0] s_a = '0;
   logic signed [DW-1:0] s_b = '0;
   logic                 mac_reset, mac_valid_in;
   logic signed [DW-1:0] mac_a, mac_b;
   logic signed [OW-1:0] mac_f;
   logic                 mac_valid_out;
   logic                 m_valid;
   logic                 m_ready = 1'b0;
   logic signed [OW-1:0] m_data;
   logic                 busy;

   mac_dot_seq #(.N(N), .DW(DW), .OW(OW)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .mac_reset(mac_reset), .mac_valid_in(mac_valid_in), .mac_a(mac_a), .mac_b(mac_b),
      .mac_f(mac_f), .mac_valid_out(mac_valid_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint sat_ref(input longint x);
      longint hi, lo;
      hi = (longint'(1) <<< (OW - 1)) - 1;
      lo = -(longint'(1) <<< (OW - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   // MAC: wide accumulator, saturated output, valid_out 3 cycles after valid_in.
   logic   v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
   longint p1 = 0, p2 = 0, acc = 0;
   always @(posedge clk) begin
      if (mac_reset) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; acc <= 0;
      end else begin
         v1 <= mac_valid_in;
         p1 <= longint'(mac_a) * longint'(mac_b);
         v2 <= v1;
         p2 <= p1;
         v3 <= v2;
         if (v2) acc <= acc + p2;
      end
   end
   assign mac_valid_out = v3;
   assign mac_f = OW'(sat_ref(acc));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int cur_a [N];
   int cur_b [N];

   function automatic longint ref_dot();
      longint s = 0;
      for (int i = 0; i < N; i++) s += longint'(cur_a[i]) * longint'(cur_b[i]);
      return sat_ref(s);
   endfunction

   // Streams cur_a/cur_b; returns with the bench in the first RUN cycle (L+1).
   task automatic load_vec(input int gap, output int last_cyc);
      int n;
      last_cyc = 0;
      for (int i = 0; i < N; i++) begin
         if (gap > 0 && i == 1) begin
            s_valid = 1'b0;
            repeat (gap) step();
         end
         s_valid = 1'b1;
         s_a = DW'(cur_a[i]);
         s_b = DW'(cur_b[i]);
         n = 0;
         while (!s_ready && n < 50) begin
            step();
            n++;
         end
         chk("load_handshake_wait", longint'(s_ready), 1);
         last_cyc = cyc;
         step();
      end
      // A pair still offered right after the Nth beat must be refused.
      s_a = DW'(-7);
      chk("s_ready_after_last_beat", longint'(s_ready), 0);
   endtask

   task automatic finish_vec(input int last_cyc, input int hold, input longint exp);
      int n, vin_cnt, vin_first, vin_last;
      vin_cnt = 0; vin_first = -1; vin_last = -1; n = 0;
      while (!m_valid && n < 60) begin
         if (mac_valid_in) begin
            if (vin_first < 0) vin_first = cyc;
            vin_last = cyc;
            vin_cnt++;
         end
         step();
         s_valid = 1'b0;
         n++;
      end
      chk("m_valid_latency", longint'(cyc - last_cyc), longint'(N + 4));
      chk("mac_valid_in_count", longint'(vin_cnt), longint'(N));
      chk("mac_valid_in_start", longint'(vin_first - last_cyc), 1);
      chk("mac_valid_in_span", longint'(vin_last - vin_first), longint'(N - 1));
      chk("m_data", longint'(m_data), exp);
      for (int k = 0; k < hold; k++) begin
         chk("stall_m_valid", longint'(m_valid), 1);
         chk("stall_m_data", longint'(m_data), exp);
         chk("stall_s_ready", longint'(s_ready), 0);
         chk("stall_mac_valid_in", longint'(mac_valid_in), 0);
         step();
      end
      m_ready = 1'b1;
      step();
      chk("m_valid_dropped", longint'(m_valid), 0);
      chk("mac_reset_in_clear", longint'(mac_reset), 1);
      step();
      chk("s_ready_in_load", longint'(s_ready), 1);
      chk("mac_reset_low_in_load", longint'(mac_reset), 0);
      chk("busy_low_in_load", longint'(busy), 0);
      chk("m_data_kept", longint'(m_data), exp);
   endtask

   task automatic run_vec(input int hold, input int gap, input longint exp);
      int l;
      m_ready = (hold == 0);
      load_vec(gap, l);
      finish_vec(l, hold, exp);
   endtask

   typedef struct {
      int     a [N];
      int     b [N];
      int     hold;
      longint exp;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int l;
      tbl[0].a = '{1, 3, 5, 7};        tbl[0].b = '{2, 4, 6, 8};       tbl[0].hold = 0; tbl[0].exp = 100;
      tbl[1].a = '{511, 511, 511, 0};  tbl[1].b = '{511, 511, 511, 0}; tbl[1].hold = 0; tbl[1].exp = 524287;
      tbl[2].a = '{-512, -512, -512, 1}; tbl[2].b = '{511, 511, 511, 1}; tbl[2].hold = 0; tbl[2].exp = -524288;
      tbl[3].a = '{1, 3, 5, 7};        tbl[3].b = '{2, 4, 6, 8};       tbl[3].hold = 5; tbl[3].exp = 100;
      tbl[4].a = '{1, 1, 1, 1};        tbl[4].b = '{1, 1, 1, 1};       tbl[4].hold = 0; tbl[4].exp = 4;

      reset = 1'b0;
      repeat (3) step();
      chk("rst_s_ready", longint'(s_ready), 0);
      chk("rst_m_valid", longint'(m_valid), 0);
      chk("rst_m_data", longint'(m_data), 0);
      chk("rst_mac_valid_in", longint'(mac_valid_in), 0);
      chk("rst_mac_a", longint'(mac_a), 0);
      chk("rst_mac_b", longint'(mac_b), 0);
      chk("rst_mac_reset", longint'(mac_reset), 1);
      chk("rst_busy", longint'(busy), 1);
      reset = 1'b1;
      step();
      chk("first_load_s_ready", longint'(s_ready), 1);

      for (int t = 0; t < 5; t++) begin
         cur_a = tbl[t].a;
         cur_b = tbl[t].b;
         run_vec(tbl[t].hold, 0, tbl[t].exp);
      end

      // Abort in the second RUN cycle, then a clean vector must see a fresh MAC.
      cur_a = '{1, 3, 5, 7};
      cur_b = '{2, 4, 6, 8};
      m_ready = 1'b1;
      load_vec(0, l);
      step();
      chk("abort_in_run", longint'(mac_valid_in), 1);
      reset = 1'b0;
      step();
      chk("abort_s_ready", longint'(s_ready), 0);
      chk("abort_m_valid", longint'(m_valid), 0);
      chk("abort_m_data", longint'(m_data), 0);
      chk("abort_mac_valid_in", longint'(mac_valid_in), 0);
      chk("abort_mac_a", longint'(mac_a), 0);
      chk("abort_mac_reset", longint'(mac_reset), 1);
      reset = 1'b1;
      step();
      chk("abort_load_s_ready", longint'(s_ready), 1);
      cur_a = '{2, 2, 2, 2};
      cur_b = '{3, 3, 3, 3};
      run_vec(0, 0, 24);

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N; i++) begin
            cur_a[i] = int'($urandom_range(0, 1023)) - 512;
            cur_b[i] = int'($urandom_range(0, 1023)) - 512;
         end
         run_vec(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), ref_dot());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

endmodule
